// File: rtl/color_mixer_stream_if.sv
// Stream bundle for color_mixer_stream: operand beats on s_*, result beats on m_*.
// m_overflow is present only when COLOR_MIXER_STREAM_OVERFLOW_FLAG_EN is defined.
interface color_mixer_stream_if #(
  parameter int SUB_PIXEL_WIDTH      = 9,
  parameter int NUMBER_OF_SUB_PIXELS = 4,
  parameter int USER_WIDTH           = 1
);
  localparam int PIXEL_WIDTH = SUB_PIXEL_WIDTH * NUMBER_OF_SUB_PIXELS;

  logic                   s_valid;
  logic                   s_ready;
  logic [PIXEL_WIDTH-1:0] s_colorA;
  logic [PIXEL_WIDTH-1:0] s_colorB;
  logic [PIXEL_WIDTH-1:0] s_colorC;
  logic [PIXEL_WIDTH-1:0] s_colorD;
  logic [1:0]             s_mode;
  logic [USER_WIDTH-1:0]  s_user;
  logic                   m_valid;
  logic                   m_ready;
  logic [PIXEL_WIDTH-1:0] m_color;
  logic [USER_WIDTH-1:0]  m_user;

`ifdef COLOR_MIXER_STREAM_OVERFLOW_FLAG_EN
  logic [NUMBER_OF_SUB_PIXELS-1:0] m_overflow;

  // Mixer side
  modport slave (
    input  s_valid, s_colorA, s_colorB, s_colorC, s_colorD, s_mode, s_user, m_ready,
    output s_ready, m_valid, m_color, m_user, m_overflow
  );

  // Source/sink side
  modport master (
    output s_valid, s_colorA, s_colorB, s_colorC, s_colorD, s_mode, s_user, m_ready,
    input  s_ready, m_valid, m_color, m_user, m_overflow
  );
`else
  // Mixer side
  modport slave (
    input  s_valid, s_colorA, s_colorB, s_colorC, s_colorD, s_mode, s_user, m_ready,
    output s_ready, m_valid, m_color, m_user
  );

  // Source/sink side
  modport master (
    output s_valid, s_colorA, s_colorB, s_colorC, s_colorD, s_mode, s_user, m_ready,
    input  s_ready, m_valid, m_color, m_user
  );
`endif
endinterface

// File: rtl/color_mixer_stream.sv
// Two-stage per-channel signed mixer (A*B +/- C*D) with rounding and saturation.
// Define COLOR_MIXER_STREAM_OVERFLOW_FLAG_EN to add the per-channel m_overflow flags.
module color_mixer_stream #(
  parameter int SUB_PIXEL_WIDTH          = 9,
  parameter int NUMBER_OF_SUB_PIXELS     = 4,
  parameter int SUB_PIXEL_CALC_PRECISION = SUB_PIXEL_WIDTH,
  parameter int USER_WIDTH               = 1
) (
  input logic                 aclk,
  input logic                 reset,
  color_mixer_stream_if.slave bus
);
  localparam int W           = SUB_PIXEL_WIDTH;
  localparam int N           = NUMBER_OF_SUB_PIXELS;
  localparam int P           = SUB_PIXEL_CALC_PRECISION;
  localparam int PIXEL_WIDTH = W * N;
  localparam int PROD_W      = 2 * P - 1;
  localparam int SUM_W       = 2 * P;
  localparam int ACC_W       = 2 * P + 1;
  localparam int FILL_W      = W - P;

  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_MUL = 2'd2;

  // 2^(P-1)-1 is both the rounding constant and the positive clip level (1.0).
  localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'((1 << (P - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ROUND_K;
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (P - 1)));

  logic                      ce;
  logic                      s1_valid;
  logic [N-1:0][PROD_W-1:0]  ab_d;
  logic [N-1:0][PROD_W-1:0]  cd_d;
  logic [N-1:0][PROD_W-1:0]  ab_q;
  logic [N-1:0][PROD_W-1:0]  cd_q;
  logic [1:0]                mode_q;
  logic [USER_WIDTH-1:0]     user_q;
  logic                      out_valid;
  logic [PIXEL_WIDTH-1:0]    color_d;
  logic [PIXEL_WIDTH-1:0]    color_q;
  logic [USER_WIDTH-1:0]     out_user;
`ifdef COLOR_MIXER_STREAM_OVERFLOW_FLAG_EN
  logic [N-1:0]              clip_d;
  logic [N-1:0]              clip_q;
`endif

  // Whole pipeline advances together; an empty output register always accepts.
  assign ce          = !out_valid || bus.m_ready;
  assign bus.s_ready = ce;
  assign bus.m_valid = out_valid;
  assign bus.m_color = color_q;
  assign bus.m_user  = out_user;
`ifdef COLOR_MIXER_STREAM_OVERFLOW_FLAG_EN
  assign bus.m_overflow = clip_q;
`endif

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic signed [P-1:0]     op_a;
    logic signed [P-1:0]     op_b;
    logic signed [P-1:0]     op_c;
    logic signed [P-1:0]     op_d;
    logic signed [SUM_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [P-1:0]     sat;
    logic                    hi;
    logic                    lo;

    // Arithmetic uses the upper P bits of each stored sub pixel.
    assign op_a = bus.s_colorA[i*W + W-1 -: P];
    assign op_b = bus.s_colorB[i*W + W-1 -: P];
    assign op_c = bus.s_colorC[i*W + W-1 -: P];
    assign op_d = bus.s_colorD[i*W + W-1 -: P];

    assign ab_d[i] = PROD_W'(op_a) * PROD_W'(op_b);
    assign cd_d[i] = PROD_W'(op_c) * PROD_W'(op_d);

    always_comb begin
      // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
      sum = SUM_W'($signed(ab_q[i])) + SUM_W'($signed(cd_q[i]));
      case (mode_q)
        MODE_SUB: sum = SUM_W'($signed(ab_q[i])) - SUM_W'($signed(cd_q[i]));
        MODE_MUL: sum = SUM_W'($signed(ab_q[i]));
        default:  sum = SUM_W'($signed(ab_q[i])) + SUM_W'($signed(cd_q[i]));
      endcase
    end

    assign shifted = (ACC_W'(sum) + ROUND_K) >>> (P - 1);
    assign hi      = shifted > SAT_MAX;
    assign lo      = shifted < SAT_MIN;
    assign sat     = hi ? SAT_MAX[P-1:0] : (lo ? SAT_MIN[P-1:0] : shifted[P-1:0]);

    if (FILL_W == 0) begin : g_exact
      assign color_d[i*W +: W] = sat;
    end else begin : g_fill
      // Low bits repeat the fraction bits so full scale stays full scale when widened.
      logic [FILL_W-1:0] fill;
      for (genvar k = 0; k < FILL_W; k++) begin : g_bit
        assign fill[FILL_W-1-k] = sat[P-2 - (k % (P-1))];
      end
      assign color_d[i*W +: W] = {sat, fill};
    end

`ifdef COLOR_MIXER_STREAM_OVERFLOW_FLAG_EN
    assign clip_d[i] = hi | lo;
`endif
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      // NOTE: data registers are cleared too so m_color/m_user read as zero straight out of reset.
      s1_valid  <= 1'b0;
      ab_q      <= '0;
      cd_q      <= '0;
      mode_q    <= '0;
      user_q    <= '0;
      out_valid <= 1'b0;
      color_q   <= '0;
      out_user  <= '0;
`ifdef COLOR_MIXER_STREAM_OVERFLOW_FLAG_EN
      clip_q    <= '0;
`endif
    end else if (ce) begin
      // NOTE: non-blocking assignments let stage 2 take stage 1's old contents on the same edge.
      s1_valid  <= bus.s_valid;
      ab_q      <= ab_d;
      cd_q      <= cd_d;
      mode_q    <= bus.s_mode;
      user_q    <= bus.s_user;
      out_valid <= s1_valid;
      color_q   <= color_d;
      out_user  <= user_q;
`ifdef COLOR_MIXER_STREAM_OVERFLOW_FLAG_EN
      clip_q    <= clip_d;
`endif
    end
  end
endmodule
